// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
// Holds the FSM state enum, the nibble width and the nibble-index width helper.
package nibble_serial_adder_ctrl_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // A single-nibble datapath still needs a 1-bit index register.
    function automatic int idx_width(input int nibs);
        return (nibs > 1) ? $clog2(nibs) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_nibble_rca_stage.sv
// Combinational 4-bit ripple-carry stage built from four full-adder cells.
// Every internal carry is exported so the caller can form signed overflow from c[3]^c[2].
module nibble_rca_stage
    import nibble_serial_adder_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0] a_i,
    input  logic [NIB_W-1:0] b_i,
    input  logic             cin_i,
    output logic [NIB_W-1:0] sum_o,
    output logic [NIB_W-1:0] c_o
);

    logic [NIB_W:0] cy;

    assign cy[0] = cin_i;

    for (genvar i = 0; i < NIB_W; i++) begin : g_fa
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ cy[i];
        assign cy[i+1]  = (a_i[i] & b_i[i]) | (cy[i] & (a_i[i] ^ b_i[i]));
    end

    assign c_o = cy[NIB_W:1];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial WIDTH-bit adder: one 4-bit stage reused LSB-first, one nibble per cycle.
// Defining NIBBLE_SERIAL_ADDER_CTRL_SUB_EN adds a sub_i port selecting a-b.
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
`ifdef NIBBLE_SERIAL_ADDER_CTRL_SUB_EN
    input  logic             sub_i,
`endif
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int NIBS  = WIDTH / NIB_W;
    localparam int IDX_W = idx_width(NIBS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBS - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [NIB_W-1:0] nib_a, nib_b, nib_sum, nib_c;
    logic [WIDTH-1:0] b_cap;
    logic             carry_cap;

    assign nib_a = a_q[idx_q*NIB_W +: NIB_W];
    assign nib_b = b_q[idx_q*NIB_W +: NIB_W];

    nibble_rca_stage u_stage (
        .a_i   (nib_a),
        .b_i   (nib_b),
        .cin_i (carry_q),
        .sum_o (nib_sum),
        .c_o   (nib_c)
    );

    // Subtraction is a + ~b + 1, so only the captured operand and seed carry differ.
`ifdef NIBBLE_SERIAL_ADDER_CTRL_SUB_EN
    assign b_cap     = sub_i ? ~b_i : b_i;
    assign carry_cap = sub_i ? 1'b1 : cin_i;
`else
    assign b_cap     = b_i;
    assign carry_cap = cin_i;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    a_d     = a_i;
                    b_d     = b_cap;
                    carry_d = carry_cap;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[idx_q*NIB_W +: NIB_W] = nib_sum;
                carry_d = nib_c[NIB_W-1];
                if (idx_q == LAST_IDX) begin
                    cout_d  = nib_c[NIB_W-1];
                    ovf_d   = nib_c[NIB_W-1] ^ nib_c[NIB_W-2];
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready_o  = (state_q == ST_IDLE);
    assign out_valid_o = (state_q == ST_DONE);
    assign sum_o       = sum_q;
    assign cout_o      = cout_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed-vector bench for nibble_serial_adder_ctrl at WIDTH=16.
// Subtract vectors are included only when NIBBLE_SERIAL_ADDER_CTRL_SUB_EN is defined.
module tb_nibble_serial_adder_ctrl;

    localparam int WIDTH = 16;
    localparam int LAT   = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    logic [WIDTH-1:0] a_i = '0;
    logic [WIDTH-1:0] b_i = '0;
    logic             cin_i = 1'b0;
    logic             sub_i = 1'b0;
    logic             out_valid_o;
    logic             out_ready_i = 1'b0;
    logic [WIDTH-1:0] sum_o;
    logic             cout_o;
    logic             ovf_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .cin_i       (cin_i),
`ifdef NIBBLE_SERIAL_ADDER_CTRL_SUB_EN
        .sub_i       (sub_i),
`endif
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .sum_o       (sum_o),
        .cout_o      (cout_o),
        .ovf_o       (ovf_o)
    );

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             sub;
        logic [WIDTH-1:0] s;
        logic             co;
        logic             ov;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Handshake one operand set, then scramble the inputs to prove they were captured.
    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c, input logic s);
        @(negedge clk);
        check("in_ready_before_launch", {31'd0, in_ready_o}, 32'd1);
        a_i = a; b_i = b; cin_i = c; sub_i = s; in_valid_i = 1'b1;
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        a_i = WIDTH'($urandom); b_i = WIDTH'($urandom); cin_i = 1'b1; sub_i = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (out_valid_o !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic pop();
        @(negedge clk);
        out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        out_ready_i = 1'b0;
        check("in_ready_after_pop", {31'd0, in_ready_o}, 32'd1);
        check("out_valid_after_pop", {31'd0, out_valid_o}, 32'd0);
    endtask

    task automatic check_result(input vec_t v, input int lat);
        check("latency", lat, LAT);
        check("sum", {16'd0, sum_o}, {16'd0, v.s});
        check("cout", {31'd0, cout_o}, {31'd0, v.co});
        check("ovf", {31'd0, ovf_o}, {31'd0, v.ov});
    endtask

    initial begin
        int lat;
        vec_t v;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[7] = '{16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[8] = '{16'h1234, 16'hEDCB, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[9] = '{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};

        #2;
        check("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        check("rst_sum", {16'd0, sum_o}, 32'd0);
        check("rst_cout_ovf", {30'd0, cout_o, ovf_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("idle_hold", {13'd0, in_ready_o, out_valid_o, cout_o, sum_o}, 32'h0004_0000);
        end

        // First vector also exercises a stalled consumer.
        for (int i = 0; i < 10; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
            check("in_ready_in_run", {31'd0, in_ready_o}, 32'd0);
            wait_done(lat);
            check_result(vecs[i], lat);
            if (i == 0) begin
                for (int k = 0; k < 5; k++) begin
                    @(posedge clk);
                    #1;
                    check("stall_valid", {31'd0, out_valid_o}, 32'd1);
                    check("stall_sum", {14'd0, cout_o, ovf_o, sum_o}, {16'd0, vecs[0].s});
                end
            end
            pop();
        end

        // in_valid and new operands during RUN/DONE must be ignored.
        launch(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(negedge clk);
        a_i = 16'hFFFF; b_i = 16'hFFFF; cin_i = 1'b1; in_valid_i = 1'b1;
        check("busy_in_ready", {31'd0, in_ready_o}, 32'd0);
        wait_done(lat);
        @(negedge clk);
        in_valid_i = 1'b0;
        v = '{16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0};
        check_result(v, lat);
        pop();
        @(posedge clk);
        #1;
        check("no_spurious_start", {30'd0, in_ready_o, out_valid_o}, 32'd2);

        // Reset during the second RUN step discards the transaction.
        launch(16'h1234, 16'h4321, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrun_rst_state", {30'd0, in_ready_o, out_valid_o}, 32'd2);
        check("midrun_rst_regs", {15'd0, cout_o, ovf_o, sum_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (out_valid_o === 1'b1 || in_ready_o !== 1'b1) lat++;
        end
        check("after_rst_quiet", lat, 0);

        launch(16'h0001, 16'h0002, 1'b0, 1'b0);
        wait_done(lat);
        v = '{16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0};
        check_result(v, lat);
        pop();

`ifdef NIBBLE_SERIAL_ADDER_CTRL_SUB_EN
        launch(16'h0005, 16'h0007, 1'b0, 1'b1);
        wait_done(lat);
        v = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        check_result(v, lat);
        pop();
        launch(16'h8000, 16'h0001, 1'b0, 1'b1);
        wait_done(lat);
        v = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        check_result(v, lat);
        pop();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
